// File: rtl/ant_iq_sender.sv
// Framer for one antenna block: a header followed by RE_NUM RE words, sent out as an addressed stream.
// Even and odd blocks alternate, and each block ends with exactly one last flag followed by an idle gap.
module ant_iq_sender #(
    parameter int ANT        = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int RE_NUM     = 1584,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_hdr_vld,
    input  logic [63:0]           i_hdr_info0,
    input  logic [7:0]            i_hdr_agc,
    output logic                  o_hdr_rdy,
    input  logic [ANT*32-1:0]     i_re_data,
    input  logic                  i_re_vld,
    output logic                  o_re_rdy,
    output logic [63:0]           o_info_0,
    output logic [7:0]            o_info_1,
    output logic [ADDR_WIDTH-1:0] o_iq_addr,
    output logic [ANT*32-1:0]     o_iq_data,
    output logic                  o_iq_vld,
    output logic                  o_iq_last,
    output logic                  o_ant_par,
    output logic                  o_pair_err,
    output logic [15:0]           o_blk_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RE_NUM - 1);
    localparam logic [3:0]            GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic                    hdr_rdy_reg, hdr_rdy_next;
    logic                    re_rdy_reg, re_rdy_next;
    logic [ADDR_WIDTH-1:0]   re_cnt_reg, re_cnt_next;
    logic [3:0]              gap_cnt_reg, gap_cnt_next;
    logic [63:0]             info0_reg, info0_next;
    logic [7:0]              info1_reg, info1_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    vld_reg, vld_next;
    logic                    last_reg, last_next;
    logic                    par_reg, par_next;
    logic                    pair_err_reg, pair_err_next;
    logic [10:0]             even_ref_reg, even_ref_next;
    logic [15:0]             blk_cnt_reg, blk_cnt_next;
    logic [ANT*32-1:0]       data_reg;

    logic hdr_acc;
    logic re_hs;
    logic re_final;

    // The ready registers are only ever high in their own state, so the handshakes imply the state.
    assign hdr_acc  = i_hdr_vld & hdr_rdy_reg;
    assign re_hs    = i_re_vld & re_rdy_reg;
    assign re_final = re_hs && (re_cnt_reg == LAST_IDX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            hdr_rdy_reg  <= 1'b0;
            re_rdy_reg   <= 1'b0;
            re_cnt_reg   <= '0;
            gap_cnt_reg  <= '0;
            info0_reg    <= '0;
            info1_reg    <= '0;
            addr_reg     <= '0;
            vld_reg      <= 1'b0;
            last_reg     <= 1'b0;
            par_reg      <= 1'b0;
            pair_err_reg <= 1'b0;
            even_ref_reg <= '0;
            blk_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            hdr_rdy_reg  <= hdr_rdy_next;
            re_rdy_reg   <= re_rdy_next;
            re_cnt_reg   <= re_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            info0_reg    <= info0_next;
            info1_reg    <= info1_next;
            addr_reg     <= addr_next;
            vld_reg      <= vld_next;
            last_reg     <= last_next;
            par_reg      <= par_next;
            pair_err_reg <= pair_err_next;
            even_ref_reg <= even_ref_next;
            blk_cnt_reg  <= blk_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        re_cnt_next   = re_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        info0_next    = info0_reg;
        info1_next    = info1_reg;
        addr_next     = addr_reg;
        vld_next      = 1'b0;
        last_next     = 1'b0;
        par_next      = par_reg;
        pair_err_next = 1'b0;
        even_ref_next = even_ref_reg;
        blk_cnt_next  = blk_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (hdr_acc) begin
                    info0_next  = i_hdr_info0;
                    info1_next  = i_hdr_agc;
                    re_cnt_next = '0;
                    // Odd block must carry the same slot/symbol as its even partner.
                    if (par_reg)
                        pair_err_next = (i_hdr_info0[18:8] != even_ref_reg);
                    else
                        even_ref_next = i_hdr_info0[18:8];
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (re_hs) begin
                    vld_next  = 1'b1;
                    addr_next = re_cnt_reg;
                    if (re_final) begin
                        last_next    = 1'b1;
                        re_cnt_next  = '0;
                        par_next     = ~par_reg;
                        blk_cnt_next = blk_cnt_reg + 16'd1;
                        gap_cnt_next = GAP_LOAD;
                        state_next   = ST_GAP;
                    end else begin
                        re_cnt_next = re_cnt_reg + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == 4'd0)
                    state_next = ST_IDLE;
                else
                    gap_cnt_next = gap_cnt_reg - 4'd1;
            end
            default: state_next = ST_IDLE;
        endcase

        hdr_rdy_next = (state_next == ST_IDLE);
        re_rdy_next  = (state_next == ST_SEND);
    end

    // Data path per antenna lane; holds through upstream bubbles.
    generate
        for (genvar gi = 0; gi < ANT; gi++) begin : g_lane
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset)
                    data_reg[gi*32 +: 32] <= '0;
                else if (re_hs)
                    data_reg[gi*32 +: 32] <= i_re_data[gi*32 +: 32];
            end
        end
    endgenerate

    assign o_hdr_rdy  = hdr_rdy_reg;
    assign o_re_rdy   = re_rdy_reg;
    assign o_info_0   = info0_reg;
    assign o_info_1   = info1_reg;
    assign o_iq_addr  = addr_reg;
    assign o_iq_data  = data_reg;
    assign o_iq_vld   = vld_reg;
    assign o_iq_last  = last_reg;
    assign o_ant_par  = par_reg;
    assign o_pair_err = pair_err_reg;
    assign o_blk_cnt  = blk_cnt_reg;

endmodule

// File: tb/tb_ant_iq_sender.sv
// Scoreboard bench for ant_iq_sender: the driver queues the expected words and a negedge monitor checks the output stream.
module tb_ant_iq_sender;

    localparam int ANT        = 4;
    localparam int ADDR_WIDTH = 11;
    localparam int RE_NUM     = 1584;
    localparam int GAP_CYCLES = 4;
    localparam int DW         = ANT * 32;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic                  i_hdr_vld;
    logic [63:0]           i_hdr_info0;
    logic [7:0]            i_hdr_agc;
    logic                  o_hdr_rdy;
    logic [DW-1:0]         i_re_data;
    logic                  i_re_vld;
    logic                  o_re_rdy;
    logic [63:0]           o_info_0;
    logic [7:0]            o_info_1;
    logic [ADDR_WIDTH-1:0] o_iq_addr;
    logic [DW-1:0]         o_iq_data;
    logic                  o_iq_vld;
    logic                  o_iq_last;
    logic                  o_ant_par;
    logic                  o_pair_err;
    logic [15:0]           o_blk_cnt;

    ant_iq_sender #(
        .ANT(ANT), .ADDR_WIDTH(ADDR_WIDTH), .RE_NUM(RE_NUM), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_hdr_vld(i_hdr_vld), .i_hdr_info0(i_hdr_info0),
        .i_hdr_agc(i_hdr_agc), .o_hdr_rdy(o_hdr_rdy), .i_re_data(i_re_data),
        .i_re_vld(i_re_vld), .o_re_rdy(o_re_rdy), .o_info_0(o_info_0), .o_info_1(o_info_1),
        .o_iq_addr(o_iq_addr), .o_iq_data(o_iq_data), .o_iq_vld(o_iq_vld),
        .o_iq_last(o_iq_last), .o_ant_par(o_ant_par), .o_pair_err(o_pair_err),
        .o_blk_cnt(o_blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DW-1:0]         data;
        logic                  last;
    } exp_t;

    exp_t                  sb_q[$];
    int                    n_checks = 0;
    int                    n_errors = 0;
    int                    pair_pulses = 0;
    bit                    model_par = 1'b0;
    logic [10:0]           model_ref = '0;
    logic [15:0]           model_blk = '0;
    bit                    hold_ok = 1'b0;
    logic [ADDR_WIDTH-1:0] prev_addr = '0;
    logic [DW-1:0]         prev_data = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [6:0] slot, input logic [3:0] sym,
                                           input logic [23:0] tag);
        logic [63:0] h;
        h         = '0;
        h[63:40]  = tag;
        h[39:36]  = 4'h1;
        h[19]     = 1'b1;
        h[18:12]  = slot;
        h[11:8]   = sym;
        return h;
    endfunction

    task automatic check_reset_outputs();
        check("rst_hdr_rdy", o_hdr_rdy, 0);
        check("rst_re_rdy", o_re_rdy, 0);
        check("rst_info_0", o_info_0, 0);
        check("rst_info_1", o_info_1, 0);
        check("rst_iq_addr", o_iq_addr, 0);
        check("rst_iq_data", o_iq_data, 0);
        check("rst_iq_vld", o_iq_vld, 0);
        check("rst_iq_last", o_iq_last, 0);
        check("rst_ant_par", o_ant_par, 0);
        check("rst_pair_err", o_pair_err, 0);
        check("rst_blk_cnt", o_blk_cnt, 0);
    endtask

    // Output monitor: pops the scoreboard on every valid word, checks hold behaviour on bubbles.
    always @(negedge clk) begin
        if (o_pair_err) pair_pulses++;
        if (i_reset) begin
            hold_ok = 1'b0;
        end else begin
            if (o_iq_vld) begin
                if (sb_q.size() == 0) begin
                    check("spurious_vld", o_iq_vld, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("iq_addr", o_iq_addr, e.addr);
                    check("iq_data", o_iq_data, e.data);
                    check("iq_last", o_iq_last, e.last);
                end
            end else begin
                check("last_without_vld", o_iq_last, 0);
                if (hold_ok) begin
                    check("addr_hold", o_iq_addr, prev_addr);
                    check("data_hold", o_iq_data, prev_data);
                end
            end
            prev_addr = o_iq_addr;
            prev_data = o_iq_data;
            hold_ok   = 1'b1;
        end
    end

    // One header plus RE_NUM words. RE words are offered in IDLE and GAP too, and must be ignored.
    task automatic send_block(input logic [63:0] hdr, input logic [7:0] agc, input int bubble_pct,
                              input bit hold_hdr, input logic [63:0] next_hdr, input int abort_at);
        int            guard;
        int            idx;
        int            k;
        bit            v;
        bit            exp_err;
        logic [DW-1:0] d;
        i_hdr_info0 = hdr;
        i_hdr_agc   = agc;
        i_hdr_vld   = 1'b1;
        i_re_vld    = 1'b1;
        i_re_data   = {$urandom, $urandom, $urandom, $urandom};
        guard = 0;
        while (!o_hdr_rdy && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 64) begin
            check("hdr_rdy_timeout", guard, 0);
            i_hdr_vld = 1'b0;
            i_re_vld  = 1'b0;
            return;
        end
        exp_err = model_par && (hdr[18:8] != model_ref);
        if (!model_par) model_ref = hdr[18:8];
        @(posedge clk); #1;
        i_hdr_vld = hold_hdr;
        if (hold_hdr) begin
            i_hdr_info0 = next_hdr;
            i_hdr_agc   = ~agc;
        end
        check("acc_info_0", o_info_0, hdr);
        check("acc_info_1", o_info_1, agc);
        check("acc_pair_err", o_pair_err, exp_err);
        check("acc_hdr_rdy", o_hdr_rdy, 0);
        check("acc_re_rdy", o_re_rdy, 1);

        idx   = 0;
        guard = 0;
        while (idx < RE_NUM) begin
            if (idx == abort_at) begin
                i_reset   = 1'b1;
                i_re_vld  = 1'b0;
                i_hdr_vld = 1'b0;
                #1;
                check_reset_outputs();
                sb_q.delete();
                model_par = 1'b0;
                model_ref = '0;
                model_blk = '0;
                repeat (2) @(posedge clk);
                #1;
                i_reset = 1'b0;
                return;
            end
            v = ($urandom_range(99) >= bubble_pct);
            d = {$urandom, $urandom, $urandom, $urandom};
            i_re_vld  = v;
            i_re_data = d;
            if (v && o_re_rdy) begin
                sb_q.push_back('{addr: ADDR_WIDTH'(idx), data: d, last: (idx == RE_NUM - 1)});
                idx++;
            end
            @(posedge clk); #1;
            check("send_info_hold", o_info_0, hdr);
            check("send_hdr_rdy", o_hdr_rdy, 0);
            guard++;
            if (guard > 8 * RE_NUM) begin
                check("re_loop_timeout", guard, 8 * RE_NUM);
                i_re_vld = 1'b0;
                return;
            end
        end

        i_re_vld  = 1'b1;
        i_re_data = {$urandom, $urandom, $urandom, $urandom};
        model_par = ~model_par;
        model_blk = model_blk + 16'd1;
        check("blk_par", o_ant_par, model_par);
        check("blk_cnt", o_blk_cnt, model_blk);
        check("last_re_rdy", o_re_rdy, 0);
        k = 0;
        while (!o_hdr_rdy && k < 64) begin
            @(posedge clk); #1;
            k++;
            check("gap_info_hold", o_info_0, hdr);
        end
        check("gap_cycles", k, GAP_CYCLES);
    endtask

    initial begin
        logic [63:0] h_e;
        logic [63:0] h_o;
        i_reset     = 1'b1;
        i_hdr_vld   = 1'b0;
        i_hdr_info0 = '0;
        i_hdr_agc   = '0;
        i_re_vld    = 1'b0;
        i_re_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        i_reset = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_reset", o_hdr_rdy, 1);

        // Back-to-back even/odd pair, slot 4 symbol 0.
        h_e = mk_hdr(7'd4, 4'd0, 24'h00A001);
        h_o = mk_hdr(7'd4, 4'd0, 24'h00A002);
        send_block(h_e, 8'h11, 0, 1'b0, '0, -1);
        send_block(h_o, 8'h22, 0, 1'b0, '0, -1);
        check("b2b_blk_cnt", o_blk_cnt, 2);
        check("b2b_par", o_ant_par, 0);
        check("b2b_no_pair_err", pair_pulses, 0);

        // Even block with 50% upstream bubbles.
        send_block(mk_hdr(7'd5, 4'd1, 24'h00B001), 8'h33, 50, 1'b0, '0, -1);

        // Odd block while the next header is held valid through SEND and GAP.
        h_e = mk_hdr(7'd6, 4'd3, 24'h00C002);
        send_block(mk_hdr(7'd5, 4'd1, 24'h00C001), 8'h44, 0, 1'b1, h_e, -1);

        // Pair mismatch: even symbol 3, odd symbol 4.
        send_block(h_e, 8'hBB, 0, 1'b0, '0, -1);
        send_block(mk_hdr(7'd6, 4'd4, 24'h00D001), 8'h55, 0, 1'b0, '0, -1);
        check("mismatch_pulses", pair_pulses, 1);

        // Reset at addr 700 of an odd block, then restart as even.
        h_e = mk_hdr(7'd9, 4'd2, 24'h00E001);
        send_block(h_e, 8'h66, 0, 1'b0, '0, -1);
        send_block(mk_hdr(7'd9, 4'd2, 24'h00E002), 8'h77, 0, 1'b0, '0, 700);
        check("post_reset_par", o_ant_par, 0);
        send_block(mk_hdr(7'd10, 4'd5, 24'h00F001), 8'h88, 0, 1'b0, '0, -1);
        check("restart_blk_cnt", o_blk_cnt, 1);

        // Block counter wrap from a preloaded value.
        force dut.blk_cnt_reg = 16'hFFFE;
        @(posedge clk); #1;
        release dut.blk_cnt_reg;
        model_blk = 16'hFFFE;
        check("wrap_preload", o_blk_cnt, 16'hFFFE);
        send_block(mk_hdr(7'd10, 4'd5, 24'h010001), 8'h99, 0, 1'b0, '0, -1);
        send_block(mk_hdr(7'd11, 4'd6, 24'h010002), 8'hAA, 0, 1'b0, '0, -1);
        check("wrap_zero", o_blk_cnt, 0);
        send_block(mk_hdr(7'd11, 4'd6, 24'h010003), 8'hCC, 0, 1'b0, '0, -1);
        check("wrap_one", o_blk_cnt, 1);
        check("wrap_par", o_ant_par, 0);

        i_re_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sb_leftover", sb_q.size(), 0);
        check("total_pair_pulses", pair_pulses, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
